// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and the data stage.
// One transaction in flight, data-first priority with a fetch starvation guard.
module mem_port_arbiter #(
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        ifReq,
    input  logic [31:0] ifAddr,
    output logic [31:0] ifRdata,
    output logic        ifValid,
    output logic        ifStall,
    input  logic        dmReq,
    input  logic        dmWe,
    input  logic [31:0] dmAddr,
    input  logic [31:0] dmWdata,
    input  logic [3:0]  dmMask,
    output logic [31:0] dmRdata,
    output logic        dmValid,
    output logic        dmStall,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    output logic [3:0]  memMask,
    input  logic        memGnt,
    input  logic        memRvalid,
    input  logic [31:0] memRdata,
    output logic        busError
);

    localparam int SW = (MAX_DATA_STREAK > 0) ? $clog2(MAX_DATA_STREAK + 1) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);
    localparam logic [TW-1:0] TO_LAST =
        TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          owner_q;     // 1 = data, 0 = fetch
    logic [31:0]   addr_q;
    logic          we_q;
    logic [31:0]   wdata_q;
    logic [3:0]    mask_q;
    logic [SW-1:0] streak_q;
    logic [TW-1:0] to_cnt_q;
    logic          abort_q;
    logic [31:0]   if_rdata_q;
    logic [31:0]   dm_rdata_q;

    logic sel_dm;
    logic sel_if;
    logic in_flight;
    logic complete;
    logic timeout_hit;
    logic finish;

    // Arbitration and completion conditions shared by the FSM and datapath.
    always_comb begin
        sel_dm      = dmReq && !(ifReq && (streak_q == STREAK_MAX));
        sel_if      = !sel_dm && ifReq;
        in_flight   = (state_q == REQ) || (state_q == RESP);
        complete    = ((state_q == REQ) && memGnt && memRvalid) ||
                      ((state_q == RESP) && memRvalid);
        timeout_hit = TO_EN && in_flight && !complete &&
                      (to_cnt_q == TO_LAST);
        finish      = complete || timeout_hit;
    end

    // State register; async reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for the request/grant/response sequence.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (sel_dm || sel_if) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (finish) begin
                    state_d = DONE;
                end else if (memGnt) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (finish) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    // Decoded outputs: request strobe, completion pulses, stalls.
    always_comb begin
        memReq   = (state_q == REQ);
        ifValid  = (state_q == DONE) && !owner_q;
        dmValid  = (state_q == DONE) && owner_q;
        busError = (state_q == DONE) && abort_q;
        ifStall  = ifReq && !ifValid;
        dmStall  = dmReq && !dmValid;
    end

    assign memWe    = we_q;
    assign memAddr  = addr_q;
    assign memWdata = wdata_q;
    assign memMask  = mask_q;
    assign ifRdata  = if_rdata_q;
    assign dmRdata  = dm_rdata_q;

    // Latch the selected requester's access; fetches are reads with no mask.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            owner_q <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            mask_q  <= '0;
        end else if (state_q == IDLE) begin
            if (sel_dm) begin
                owner_q <= 1'b1;
                addr_q  <= dmAddr;
                we_q    <= dmWe;
                wdata_q <= dmWdata;
                mask_q  <= dmMask;
            end else if (sel_if) begin
                owner_q <= 1'b0;
                addr_q  <= ifAddr;
                we_q    <= 1'b0;
                wdata_q <= '0;
                mask_q  <= '0;
            end
        end
    end

    // Count data wins while fetch waits, so fetch cannot starve.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            streak_q <= '0;
        end else if (state_q == IDLE) begin
            if (sel_dm && ifReq) begin
                if (streak_q != STREAK_MAX) begin
                    streak_q <= streak_q + 1'b1;
                end
            end else if (sel_dm || sel_if) begin
                streak_q <= '0;
            end
        end
    end

    // Timeout counter runs only while a transaction is outstanding.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            to_cnt_q <= '0;
        end else if (state_q == IDLE) begin
            to_cnt_q <= '0;
        end else if (in_flight) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    // Capture response (or zero on abort) into the owner's hold register.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            abort_q    <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else if (finish) begin
            abort_q <= timeout_hit;
            if (owner_q) begin
                dm_rdata_q <= timeout_hit ? 32'h0 : memRdata;
            end else begin
                if_rdata_q <= timeout_hit ? 32'h0 : memRdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: driver tasks push expected results,
// a negedge monitor pops them on each valid pulse; memory is a delay model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        arst;
    logic        ifReq;
    logic [31:0] ifAddr;
    logic [31:0] ifRdata;
    logic        ifValid;
    logic        ifStall;
    logic        dmReq;
    logic        dmWe;
    logic [31:0] dmAddr;
    logic [31:0] dmWdata;
    logic [3:0]  dmMask;
    logic [31:0] dmRdata;
    logic        dmValid;
    logic        dmStall;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [3:0]  memMask;
    logic        memGnt;
    logic        memRvalid;
    logic [31:0] memRdata;
    logic        busError;

    mem_port_arbiter #(
        .MAX_DATA_STREAK(4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk      (clk),
        .arst     (arst),
        .ifReq    (ifReq),
        .ifAddr   (ifAddr),
        .ifRdata  (ifRdata),
        .ifValid  (ifValid),
        .ifStall  (ifStall),
        .dmReq    (dmReq),
        .dmWe     (dmWe),
        .dmAddr   (dmAddr),
        .dmWdata  (dmWdata),
        .dmMask   (dmMask),
        .dmRdata  (dmRdata),
        .dmValid  (dmValid),
        .dmStall  (dmStall),
        .memReq   (memReq),
        .memWe    (memWe),
        .memAddr  (memAddr),
        .memWdata (memWdata),
        .memMask  (memMask),
        .memGnt   (memGnt),
        .memRvalid(memRvalid),
        .memRdata (memRdata),
        .busError (busError)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        bit          err;
    } exp_t;

    exp_t if_q[$];
    exp_t dm_q[$];
    bit   seq_q[$];
    bit   rec_seq = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents are a fixed function of the address.
    function automatic logic [31:0] hash(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- memory model ----------------
    int gd = 0;
    int rd = 0;
    bit rnd = 1'b0;
    bit mute = 1'b0;
    bit stray = 1'b0;
    int grants = 0;

    initial begin
        int mstate;
        int gcnt;
        int rcnt;
        logic [31:0] pend;
        bit m_if;
        bit m_dm;
        mstate = 0;
        gcnt = 0;
        rcnt = 0;
        pend = '0;
        memGnt = 1'b0;
        memRvalid = 1'b0;
        memRdata = '0;
        forever begin
            @(posedge clk);
            #1;
            memGnt = 1'b0;
            memRvalid = 1'b0;
            memRdata = $urandom;
            if (arst) begin
                mstate = 0;
                gcnt = 0;
            end else if (stray) begin
                memGnt = 1'b1;
                memRvalid = 1'b1;
            end else if (mstate == 0) begin
                if (memReq && !mute) begin
                    if (gcnt >= gd) begin
                        memGnt = 1'b1;
                        grants++;
                        m_if = ifReq && memAddr == ifAddr && !memWe &&
                               memMask == 4'h0 && memWdata == 32'h0;
                        m_dm = dmReq && memAddr == dmAddr && memWe == dmWe &&
                               memWdata == dmWdata && memMask == dmMask;
                        chk("gnt_match", {31'b0, m_if || m_dm}, 32'd1);
                        pend = hash(memAddr);
                        gcnt = 0;
                        if (rd == 0) begin
                            memRvalid = 1'b1;
                            memRdata = pend;
                            if (rnd) begin
                                gd = $urandom_range(0, 3);
                                rd = $urandom_range(0, 3);
                            end
                        end else begin
                            mstate = 1;
                            rcnt = 0;
                        end
                    end else begin
                        gcnt++;
                    end
                end else begin
                    gcnt = 0;
                end
            end else begin
                rcnt++;
                if (rcnt >= rd) begin
                    memRvalid = 1'b1;
                    memRdata = pend;
                    mstate = 0;
                    if (rnd) begin
                        gd = $urandom_range(0, 3);
                        rd = $urandom_range(0, 3);
                    end
                end
            end
        end
    end

    // ---------------- monitor ----------------
    logic        pr_req = 1'b0;
    logic        pr_we;
    logic [31:0] pr_addr;
    logic [31:0] pr_wdata;
    logic [3:0]  pr_mask;
    logic [31:0] last_if = '0;
    logic [31:0] last_dm = '0;
    exp_t        e_if;
    exp_t        e_dm;

    always @(negedge clk) begin
        if (arst) begin
            last_if = '0;
            last_dm = '0;
            pr_req <= 1'b0;
        end else begin
            chk("if_stall", {31'b0, ifStall}, {31'b0, ifReq && !ifValid});
            chk("dm_stall", {31'b0, dmStall}, {31'b0, dmReq && !dmValid});
            chk("valid_excl", {31'b0, ifValid && dmValid}, 32'd0);
            chk("err_needs_valid",
                {31'b0, busError && !(ifValid || dmValid)}, 32'd0);
            if (memReq && pr_req) begin
                chk("hold_addr", memAddr, pr_addr);
                chk("hold_we", {31'b0, memWe}, {31'b0, pr_we});
                chk("hold_wdata", memWdata, pr_wdata);
                chk("hold_mask", {28'b0, memMask}, {28'b0, pr_mask});
            end
            pr_req   <= memReq;
            pr_we    <= memWe;
            pr_addr  <= memAddr;
            pr_wdata <= memWdata;
            pr_mask  <= memMask;
            if (ifValid) begin
                chk("if_expected", {31'b0, if_q.size() > 0}, 32'd1);
                if (if_q.size() > 0) begin
                    e_if = if_q.pop_front();
                    chk("if_rdata", ifRdata, e_if.data);
                    chk("if_err", {31'b0, busError}, {31'b0, e_if.err});
                    last_if = e_if.data;
                end
                if (rec_seq) seq_q.push_back(1'b0);
            end else begin
                chk("if_rdata_hold", ifRdata, last_if);
            end
            if (dmValid) begin
                chk("dm_expected", {31'b0, dm_q.size() > 0}, 32'd1);
                if (dm_q.size() > 0) begin
                    e_dm = dm_q.pop_front();
                    chk("dm_rdata", dmRdata, e_dm.data);
                    chk("dm_err", {31'b0, busError}, {31'b0, e_dm.err});
                    last_dm = e_dm.data;
                end
                if (rec_seq) seq_q.push_back(1'b1);
            end else begin
                chk("dm_rdata_hold", dmRdata, last_dm);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic if_txn(input logic [31:0] a, input int gap,
                          input bit hold, output int lat);
        exp_t e;
        int t0;
        bit got;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        ifReq = 1'b1;
        ifAddr = a;
        e.data = hash(a);
        e.err = 1'b0;
        if_q.push_back(e);
        t0 = cyc;
        got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(posedge clk);
            #1;
            if (ifValid) got = 1'b1;
        end
        lat = cyc - t0;
        chk("if_wait", {31'b0, got}, 32'd1);
        if (!got) if_q.delete();
        @(posedge clk);
        #1;
        if (!hold) ifReq = 1'b0;
    endtask

    task automatic dm_txn(input logic [31:0] a, input bit we,
                          input logic [31:0] wd, input logic [3:0] m,
                          input int gap, input bit err, output int lat);
        exp_t e;
        int t0;
        bit got;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        dmReq = 1'b1;
        dmWe = we;
        dmAddr = a;
        dmWdata = wd;
        dmMask = m;
        e.data = err ? 32'h0 : hash(a);
        e.err = err;
        dm_q.push_back(e);
        t0 = cyc;
        got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(posedge clk);
            #1;
            if (dmValid) got = 1'b1;
        end
        lat = cyc - t0;
        chk("dm_wait", {31'b0, got}, 32'd1);
        if (!got) dm_q.delete();
        @(posedge clk);
        #1;
        dmReq = 1'b0;
    endtask

    // Hard stop in case something wedges beyond every bounded wait.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        int g0;
        bit exp_seq[10];
        exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                    1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        arst = 1'b1;
        ifReq = 1'b0;
        ifAddr = '0;
        dmReq = 1'b0;
        dmWe = 1'b0;
        dmAddr = '0;
        dmWdata = '0;
        dmMask = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_memReq", {31'b0, memReq}, 32'd0);
        chk("rst_memAddr", memAddr, 32'd0);
        chk("rst_ifValid", {31'b0, ifValid}, 32'd0);
        chk("rst_dmValid", {31'b0, dmValid}, 32'd0);
        chk("rst_busError", {31'b0, busError}, 32'd0);
        chk("rst_ifRdata", ifRdata, 32'd0);
        @(negedge clk);
        arst = 1'b0;
        @(posedge clk);
        #1;

        // 1: single fetch, zero-wait memory
        gd = 0;
        rd = 0;
        ifReq = 1'b1;
        ifAddr = 32'h100;
        e_push_if(32'h100);
        @(negedge clk);
        chk("t1_c0_memReq", {31'b0, memReq}, 32'd0);
        chk("t1_c0_stall", {31'b0, ifStall}, 32'd1);
        @(negedge clk);
        chk("t1_c1_memReq", {31'b0, memReq}, 32'd1);
        chk("t1_c1_memAddr", memAddr, 32'h100);
        chk("t1_c1_memWe", {31'b0, memWe}, 32'd0);
        chk("t1_c1_stall", {31'b0, ifStall}, 32'd1);
        @(negedge clk);
        chk("t1_c2_ifValid", {31'b0, ifValid}, 32'd1);
        chk("t1_c2_ifRdata", ifRdata, hash(32'h100));
        @(posedge clk);
        #1;
        ifReq = 1'b0;
        @(negedge clk);
        chk("t1_c3_ifValid", {31'b0, ifValid}, 32'd0);
        @(posedge clk);
        #1;

        // 2: store with delayed grant and response
        gd = 3;
        rd = 2;
        dm_txn(32'h2004, 1'b1, 32'hDEADBEEF, 4'hF, 0, 1'b0, lat);
        chk("t2_latency", lat, 32'd7);

        // 4: load timeout, then a stray response in IDLE
        mute = 1'b1;
        dm_txn(32'h2040, 1'b0, 32'h0, 4'h0, 0, 1'b1, lat);
        chk("t4_latency", lat, 32'd9);
        mute = 1'b0;
        stray = 1'b1;
        @(posedge clk);
        #2;
        stray = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("t4_idle_memReq", {31'b0, memReq}, 32'd0);

        // 3: both held, back-to-back, check grant order
        gd = 0;
        rd = 0;
        seq_q.delete();
        rec_seq = 1'b1;
        fork
            begin
                int l;
                for (int i = 0; i < 8; i++)
                    dm_txn(32'h3000 + 32'(i * 4), 1'b0, 32'h0, 4'h0,
                           0, 1'b0, l);
            end
            begin
                int l;
                for (int i = 0; i < 2; i++)
                    if_txn(32'h200 + 32'(i * 4), 0, 1'b0, l);
            end
        join
        rec_seq = 1'b0;
        chk("t3_seq_len", seq_q.size(), 32'd10);
        for (int i = 0; i < 10 && i < seq_q.size(); i++)
            chk($sformatf("t3_seq_%0d", i), {31'b0, seq_q[i]},
                {31'b0, exp_seq[i]});

        // 5: reset in RESP
        gd = 0;
        rd = 5;
        ifReq = 1'b1;
        ifAddr = 32'h300;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("t5_in_resp", {31'b0, memReq}, 32'd0);
        #2;
        arst = 1'b1;
        #1;
        chk("t5_async_memReq", {31'b0, memReq}, 32'd0);
        chk("t5_async_memAddr", memAddr, 32'd0);
        chk("t5_async_ifValid", {31'b0, ifValid}, 32'd0);
        chk("t5_async_ifStall", {31'b0, ifStall}, 32'd1);
        ifReq = 1'b0;
        @(posedge clk);
        #3;
        arst = 1'b0;
        @(posedge clk);
        #1;
        rd = 0;
        if_txn(32'h304, 0, 1'b0, lat);
        chk("t5_after_latency", lat, 32'd2);

        // 6: req held through DONE and one extra cycle
        g0 = grants;
        if_txn(32'h308, 0, 1'b1, lat);
        if_txn(32'h308, 0, 1'b0, lat);
        chk("t6_grants", grants - g0, 32'd2);
        chk("t6_second_latency", lat, 32'd2);

        // Random mixed traffic
        rnd = 1'b1;
        gd = $urandom_range(0, 3);
        rd = $urandom_range(0, 3);
        fork
            begin
                int l;
                for (int i = 0; i < 40; i++)
                    if_txn({20'h0, 10'($urandom_range(0, 1023)), 2'b00},
                           $urandom_range(0, 3), 1'b0, l);
            end
            begin
                int l;
                for (int i = 0; i < 40; i++)
                    dm_txn(32'h2000 + {20'h0, 10'($urandom_range(0, 1023)), 2'b00},
                           1'($urandom_range(0, 1)), $urandom,
                           4'($urandom_range(0, 15)),
                           $urandom_range(0, 3), 1'b0, l);
            end
        join
        repeat (3) @(posedge clk);
        #1;
        chk("end_if_q_empty", if_q.size(), 32'd0);
        chk("end_dm_q_empty", dm_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    task automatic e_push_if(input logic [31:0] a);
        exp_t e;
        e.data = hash(a);
        e.err = 1'b0;
        if_q.push_back(e);
    endtask

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified memory port between instruction fetch (IF) and the data-memory interface (MEM stage).
- Sequences each access through a request/grant/response handshake, one transaction in flight.
- Arbitrates with data-first priority plus a starvation guard for fetch.
- Generates per-requester stall signals for the pipeline and a timeout error.

Parameters:
MAX_DATA_STREAK, 4, consecutive data grants allowed while fetch is pending; after that, fetch wins the next arbitration
TIMEOUT_CYCLES, 255, cycles spent in REQ+RESP before the transaction is aborted; 0 disables the timeout

Ports:
clk  in  1  clock, rising edge
arst  in  1  asynchronous reset, active-high
ifReq  in  1  fetch request; held until ifValid
ifAddr  in  32  fetch address
ifRdata  out  32  fetched word
ifValid  out  1  one-cycle fetch completion pulse
ifStall  out  1  ifReq && !ifValid
dmReq  in  1  data request (load or store); held until dmValid
dmWe  in  1  1 = store
dmAddr  in  32  data address
dmWdata  in  32  store data
dmMask  in  4  byte write mask
dmRdata  out  32  load data
dmValid  out  1  one-cycle data completion pulse
dmStall  out  1  dmReq && !dmValid
memReq  out  1  memory request
memWe  out  1  memory write enable
memAddr  out  32  memory address
memWdata  out  32  memory write data
memMask  out  4  memory write mask
memGnt  in  1  request accepted
memRvalid  in  1  response valid (load data or store ack)
memRdata  in  32  response data
busError  out  1  one-cycle pulse on timeout, coincident with the aborted requester's valid

Behaviour:
- Reset (arst=1, asynchronous):
  - State IDLE; owner=IF; streakCnt=0; timeout counter=0.
  - All outputs 0, except ifStall/dmStall, which follow their combinational definitions.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - If dmReq: select data, unless ifReq && streakCnt==MAX_DATA_STREAK, in which case select fetch.
  - Else if ifReq: select fetch.
  - On a selection: latch owner, addr, we (0 for fetch), wdata, and mask (0 for fetch) into registers driving mem*. Go to REQ.
- REQ: memReq=1 and mem* held stable until memGnt.
  - memGnt && memRvalid in the same cycle: capture memRdata, go to DONE.
  - memGnt only: go to RESP.
- RESP: memReq=0, wait for memRvalid; capture memRdata, go to DONE. A memRvalid outside REQ/RESP is ignored.
- DONE: for exactly one cycle, assert the owner's valid and drive its rdata from the captured register (stores return the captured value, don't-care). Then go to IDLE.
  - Requesters drop or change req in the cycle after valid.
  - Requests are never sampled in DONE, so a held req is not double-served.
- Minimum latency: req seen in IDLE at cycle 0 -> memReq at cycle 1 -> (gnt+rvalid at 1) -> valid at cycle 2 -> IDLE at cycle 3.
- Streak counter: updated at each arbitration in IDLE.
  - Data grant with ifReq pending: increment, saturating at MAX_DATA_STREAK.
  - Fetch grant, or a data grant with no ifReq: reset to 0.
- Timeout: counter runs in REQ/RESP and clears on entering REQ. When it reaches TIMEOUT_CYCLES:
  - Abort to DONE with rdata=0 and busError=1.
  - memReq drops immediately.
  - Late memGnt/memRvalid are ignored.
- ifRdata/dmRdata hold their last value outside valid cycles.
- Reset mid-transaction: immediate return to IDLE; memReq drops asynchronously; no valid pulse.

Test Plan:
1. ifReq=1, ifAddr=0x100; memory gives gnt+rvalid at once, rdata=0x00000013 -> memReq at cycle 1 with memAddr=0x100, memWe=0; ifValid=1 with ifRdata=0x13 at cycle 2; ifStall=1 at cycles 0-1.
2. dmReq=1, dmWe=1, dmAddr=0x2004, dmWdata=0xDEADBEEF, dmMask=0xF; gnt delayed 3 cycles, rvalid 2 cycles later -> mem* stable throughout REQ; dmValid one pulse; no fetch activity.
3. ifReq and dmReq held continuously with back-to-back traffic, MAX_DATA_STREAK=4 -> grant sequence D,D,D,D,I,D,D,D,D,I.
4. TIMEOUT_CYCLES=8; memGnt never asserted for a dmReq load -> after 8 cycles: busError=1 and dmValid=1 with dmRdata=0; a later stray memRvalid is ignored.
5. arst pulsed during RESP -> outputs zero asynchronously, state IDLE; the next ifReq completes normally.
6. ifReq held high through its DONE cycle and one extra cycle -> exactly one ifValid per transaction; the second request issues from IDLE.
